// File: rtl/gt_mem_pkg.sv
// gt_mem_pkg: shared types and constants for the L1 miss controller and its writeback buffer.
// Line geometry and the controller state encoding live here so both files agree.
package gt_mem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VC_LOOKUP,
    S_MEM_WB,
    S_MEM_READ,
    S_RESP
  } state_e;

  function automatic logic [31:0] line_align(input logic [31:0] a);
    return a & ~((32'd1 << OFFSET_W) - 32'd1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/gt_wb_buf.sv
// gt_wb_buf: one-entry holding register for victim-cache writebacks awaiting a memory slot.
// A push in the same cycle as a pop wins, so a late writeback is never lost by the drain.
module gt_wb_buf
  import gt_mem_pkg::*;
#(
  parameter int LINE_W = gt_mem_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [31:0]       push_addr,
  input  logic [LINE_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic [31:0]       addr,
  output logic [LINE_W-1:0] data,
  output logic              overflow
);

  logic              full_q, full_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (push) begin
      full_d = 1'b1;
      addr_d = push_addr;
      data_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full     = full_q;
  assign addr     = addr_q;
  assign data     = data_q;
  assign overflow = push && full_q && !pop;

endmodule

// File: rtl/gt_miss_ctrl.sv
// gt_miss_ctrl: L1 line-fill controller -- victim cache first, main memory on a miss, with
// buffered victim writebacks drained ahead of reads. GT_MISS_CTRL_STATS_EN adds counters and err.
module gt_miss_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int LINE_W  = gt_mem_pkg::LINE_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              evict_valid,
  input  logic [31:0]       evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_src,
  output logic [31:0]       vc_addr,
  output logic [LINE_W-1:0] vc_wdata,
  input  logic              vc_hit,
  input  logic [LINE_W-1:0] vc_rdata,
  input  logic              vc_wb_valid,
  input  logic [31:0]       vc_wb_addr,
  input  logic [LINE_W-1:0] vc_wb_data,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef GT_MISS_CTRL_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [15:0]       wb_cnt,
  output logic              err
`endif
);
  import gt_mem_pkg::*;

  state_e            state_q, state_d, ret_q, ret_d;
  logic [31:0]       line_q, line_d, vc_addr_q, vc_addr_d, mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d, resp_src_q, resp_src_d, mem_we_q, mem_we_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d, mem_wdata_q, mem_wdata_d;
  logic              wb_pop, wb_full;
  logic [31:0]       wb_addr;
  logic [LINE_W-1:0] wb_data;
`ifdef GT_MISS_CTRL_STATS_EN
  logic [15:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
  logic              err_q, err_d, wb_overflow;
`endif

  gt_wb_buf #(.LINE_W(LINE_W)) u_wb_buf (
    .clk       (CLK),
    .rst       (RST),
    .push      (vc_wb_valid),
    .push_addr (vc_wb_addr),
    .push_data (vc_wb_data),
    .pop       (wb_pop),
    .full      (wb_full),
    .addr      (wb_addr),
    .data      (wb_data),
`ifdef GT_MISS_CTRL_STATS_EN
    .overflow  (wb_overflow)
`else
    .overflow  ()
`endif
  );

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    vc_addr_d    = vc_addr_q;
    resp_valid_d = 1'b0;
    resp_src_d   = resp_src_q;
    resp_data_d  = resp_data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !evict_valid) begin
          line_d    = line_align(req_addr);
          vc_addr_d = line_align(req_addr);
          state_d   = S_VC_LOOKUP;
        end
      end
      S_VC_LOOKUP: begin
        if (vc_hit) begin
          resp_data_d = vc_rdata;
          resp_src_d  = 1'b0;
          state_d     = S_RESP;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (cnt_q == '0) begin
          resp_data_d = mem_rdata;
          resp_src_d  = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_MEM_WB: begin
        wb_pop  = 1'b1;
        state_d = ret_q;
      end
      default: state_d = S_IDLE;
    endcase

    // A pending writeback steals one cycle in front of any entry into a read or back to idle.
    if (wb_full && state_q != S_MEM_WB && state_d != state_q &&
        (state_d == S_MEM_READ || state_d == S_IDLE)) begin
      ret_d   = state_d;
      state_d = S_MEM_WB;
    end
    if (state_d == S_MEM_READ && state_q != S_MEM_READ) begin
      cnt_d = CNT_W'(MEM_LAT - 1);
    end

    mem_we_d = (state_d == S_MEM_WB);
    if (state_d == S_MEM_WB) begin
      mem_addr_d  = wb_addr;
      mem_wdata_d = wb_data;
    end else if (state_d == S_MEM_READ) begin
      mem_addr_d = line_q;
    end

`ifdef GT_MISS_CTRL_STATS_EN
    hit_cnt_d  = sat_inc(hit_cnt_q, state_q == S_VC_LOOKUP && vc_hit);
    miss_cnt_d = sat_inc(miss_cnt_q, state_q == S_VC_LOOKUP && !vc_hit);
    wb_cnt_d   = sat_inc(wb_cnt_q, state_q == S_MEM_WB);
    err_d      = err_q | wb_overflow;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      line_q       <= '0;
      cnt_q        <= '0;
      vc_addr_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_src_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
`ifdef GT_MISS_CTRL_STATS_EN
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      wb_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      vc_addr_q    <= vc_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_src_q   <= resp_src_d;
      resp_data_q  <= resp_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef GT_MISS_CTRL_STATS_EN
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Evictions own the victim-cache port while idle and hold off new requests for that cycle.
  assign req_ready  = (state_q == S_IDLE) && !evict_valid;
  assign vc_addr    = (state_q == S_IDLE && evict_valid) ? evict_addr : vc_addr_q;
  assign vc_wdata   = (state_q == S_IDLE && evict_valid) ? evict_data : '0;
  assign resp_valid = resp_valid_q;
  assign resp_src   = resp_src_q;
  assign resp_data  = resp_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
`ifdef GT_MISS_CTRL_STATS_EN
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign wb_cnt     = wb_cnt_q;
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_gt_miss_ctrl.sv
// tb_gt_miss_ctrl: randomized scoreboard bench for gt_miss_ctrl with memory/victim-cache models.
// Define GT_MISS_CTRL_STATS_EN to also check the statistics outputs.
module tb_gt_miss_ctrl;
  localparam int MEM_LAT = 4;
  localparam int LW      = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_ready;
  logic          evict_valid = 1'b0;
  logic [31:0]   evict_addr = '0;
  logic [LW-1:0] evict_data = '0;
  logic          resp_valid, resp_src;
  logic [LW-1:0] resp_data;
  logic [31:0]   vc_addr;
  logic [LW-1:0] vc_wdata, vc_rdata;
  logic          vc_hit = 1'b0;
  logic          vc_wb_valid = 1'b0;
  logic [31:0]   vc_wb_addr = '0;
  logic [LW-1:0] vc_wb_data = '0;
  logic [31:0]   mem_addr;
  logic          mem_we;
  logic [LW-1:0] mem_wdata, mem_rdata;
`ifdef GT_MISS_CTRL_STATS_EN
  logic [15:0]   hit_cnt, miss_cnt, wb_cnt;
  logic          err;
  int            exp_hits = 0, exp_misses = 0, exp_wbs = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [LW-1:0] data; logic src; logic [31:0] addr; int due; } exp_resp_t;
  typedef struct { logic [31:0] addr; logic [LW-1:0] data; } exp_wb_t;
  exp_resp_t resp_q[$];
  exp_wb_t   wb_q[$];
  exp_resp_t mon_r;
  exp_wb_t   mon_w;

  gt_miss_ctrl #(.MEM_LAT(MEM_LAT), .LINE_W(LW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_src(resp_src),
    .vc_addr(vc_addr), .vc_wdata(vc_wdata), .vc_hit(vc_hit), .vc_rdata(vc_rdata),
    .vc_wb_valid(vc_wb_valid), .vc_wb_addr(vc_wb_addr), .vc_wb_data(vc_wb_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef GT_MISS_CTRL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt), .err(err)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Line contents are a fixed function of the line address so any wrong address shows up as bad data.
  function automatic logic [LW-1:0] mem_line(input logic [31:0] a);
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = (a ^ (32'h9E3779B9 * 32'(i + 1))) + 32'(i);
    return v;
  endfunction

  function automatic logic [LW-1:0] vc_line(input logic [31:0] a);
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = ~a ^ (32'hC3A5_0F1E + 32'(i * 77));
    return v;
  endfunction

  assign mem_rdata = mem_line(mem_addr);
  assign vc_rdata  = vc_line(vc_addr);

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response or memory write the DUT presents must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          checkOutput("resp_unexpected", LW'(resp_valid), LW'(0));
        end else begin
          mon_r = resp_q.pop_front();
          checkOutput("resp_data", resp_data, mon_r.data);
          checkOutput("resp_src", LW'(resp_src), LW'(mon_r.src));
          checkOutput("resp_cycle", LW'(cyc), LW'(mon_r.due));
          if (mon_r.src) checkOutput("resp_mem_addr", LW'(mem_addr), LW'(mon_r.addr));
        end
      end
      if (mem_we) begin
        if (wb_q.size() == 0) begin
          checkOutput("mem_we_unexpected", LW'(mem_we), LW'(0));
        end else begin
          mon_w = wb_q.pop_front();
          checkOutput("wb_mem_addr", LW'(mem_addr), LW'(mon_w.addr));
          checkOutput("wb_mem_wdata", mem_wdata, mon_w.data);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic hit, input logic do_wb,
                               input logic [31:0] wa, input logic [LW-1:0] wd, input logic do_evict);
    int guard;
    exp_resp_t e;
    exp_wb_t w;
    logic [31:0] line;
    line = addr & 32'hFFFF_FFE0;
    guard = 0;
    @(negedge CLK);
    while (!req_ready && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    checkOutput("idle_timeout", LW'(req_ready), LW'(1));
    @(posedge CLK); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    vc_hit    = hit;
    if (do_evict) begin
      evict_valid = 1'b1;
      evict_addr  = $urandom;
      evict_data  = vc_line(~evict_addr);
      @(negedge CLK);
      checkOutput("evict_vc_addr", LW'(vc_addr), LW'(evict_addr));
      checkOutput("evict_vc_wdata", vc_wdata, evict_data);
      checkOutput("evict_req_ready", LW'(req_ready), LW'(0));
      @(posedge CLK); #1;
      evict_valid = 1'b0;
    end
    if (do_wb) begin
      vc_wb_valid = 1'b1;
      vc_wb_addr  = wa;
      vc_wb_data  = wd;
      w.addr = wa;
      w.data = wd;
      wb_q.push_back(w);
    end
    @(negedge CLK);
    checkOutput("req_ready_idle", LW'(req_ready), LW'(1));
    e.data = hit ? vc_line(line) : mem_line(line);
    e.src  = !hit;
    e.addr = line;
    e.due  = cyc + 3 + (hit ? 0 : MEM_LAT + (do_wb ? 1 : 0));
    resp_q.push_back(e);
`ifdef GT_MISS_CTRL_STATS_EN
    if (hit) exp_hits++; else exp_misses++;
    if (do_wb) exp_wbs++;
`endif
    @(posedge CLK); #1;
    req_valid   = 1'b0;
    vc_wb_valid = 1'b0;
    @(negedge CLK);
    checkOutput("vc_addr_lookup", LW'(vc_addr), LW'(line));
    checkOutput("req_ready_busy", LW'(req_ready), LW'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_req_ready", LW'(req_ready), LW'(1));
    checkOutput("rst_resp_valid", LW'(resp_valid), LW'(0));
    checkOutput("rst_resp_src", LW'(resp_src), LW'(0));
    checkOutput("rst_resp_data", resp_data, LW'(0));
    checkOutput("rst_mem_we", LW'(mem_we), LW'(0));
    checkOutput("rst_mem_addr", LW'(mem_addr), LW'(0));
    checkOutput("rst_vc_addr", LW'(vc_addr), LW'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    applyStimulus(32'h0300_0003, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    applyStimulus(32'h0700_0007, 1'b0, 1'b0, 32'h0, '0, 1'b0);
    applyStimulus(32'h0900_0040, 1'b0, 1'b1, 32'h0100_0000, {8{32'hFFFF_0000}}, 1'b0);
    applyStimulus(32'h0500_0011, 1'b1, 1'b0, 32'h0, '0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    $urandom, {$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 4) == 0));
    end

    guard = 0;
    while ((resp_q.size() != 0 || wb_q.size() != 0) && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    checkOutput("drain_resp", LW'(resp_q.size()), LW'(0));
    checkOutput("drain_wb", LW'(wb_q.size()), LW'(0));
`ifdef GT_MISS_CTRL_STATS_EN
    checkOutput("stats_hit", LW'(hit_cnt), LW'(exp_hits));
    checkOutput("stats_miss", LW'(miss_cnt), LW'(exp_misses));
    checkOutput("stats_wb", LW'(wb_cnt), LW'(exp_wbs));
    checkOutput("stats_err_clean", LW'(err), LW'(0));
`endif

    // Reset while the read is in flight and a writeback is parked: both must vanish.
    applyStimulus(32'h0BAD_0010, 1'b0, 1'b0, 32'h0, '0, 1'b0);
    @(posedge CLK); #1;
    vc_wb_valid = 1'b1;
    vc_wb_addr  = 32'h0222_0000;
    vc_wb_data  = {8{32'h1234_5678}};
    @(posedge CLK); #1;
    vc_wb_valid = 1'b0;
    RST = 1'b1;
    resp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_req_ready", LW'(req_ready), LW'(1));
    checkOutput("midrst_resp_valid", LW'(resp_valid), LW'(0));
    checkOutput("midrst_mem_we", LW'(mem_we), LW'(0));
    checkOutput("midrst_mem_addr", LW'(mem_addr), LW'(0));
    checkOutput("midrst_resp_data", resp_data, LW'(0));
    repeat (20) @(negedge CLK);

`ifdef GT_MISS_CTRL_STATS_EN
    checkOutput("stats_hit_cleared", LW'(hit_cnt), LW'(0));
    @(posedge CLK); #1;
    vc_wb_valid = 1'b1;
    vc_wb_addr  = 32'h0333_0000;
    @(posedge CLK); #1;
    vc_wb_addr  = 32'h0444_0000;
    @(posedge CLK); #1;
    vc_wb_valid = 1'b0;
    @(negedge CLK);
    checkOutput("stats_err_overflow", LW'(err), LW'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
